// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared defaults and helpers for the STDP synapse
//
// Purpose : default parameter values, the timer-width rule and the
//           learning-event type used by stdp_synapse and spike_timer.
// Ports   : none (package).
// Config  : STDP_EXP_EN (consumed by stdp_synapse) selects the
//           dt-dependent step decay; this package is identical in both builds.

package stdp_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int WINDOW_DEF   = 15;
    localparam int W_INIT_DEF   = 128;
    localparam int LTP_STEP_DEF = 4;
    localparam int LTD_STEP_DEF = 2;

    // A timer must hold 0..WINDOW+1, where WINDOW+1 marks "no recent spike".
    function automatic int timer_width(input int window);
        return $clog2(window + 2);
    endfunction

    localparam int TIMER_W_DEF = $clog2(WINDOW_DEF + 2);

    typedef enum logic [1:0] {
        LEARN_NONE = 2'd0,
        LEARN_LTP  = 2'd1,
        LEARN_LTD  = 2'd2
    } learn_ev_e;

endpackage

// File: rtl/spike_timer.sv
// rtl/spike_timer.sv - saturating cycles-since-last-spike counter
//
// Purpose : reports how many cycles ago the last spike arrived.
//           value_o is 0 in the cycle of a spike, counts up by one per
//           cycle afterwards and sticks at WINDOW+1 (invalid).
// Ports   : clk      - clock, rising edge
//           rst_n    - asynchronous active-low reset (timer -> invalid)
//           spike_i  - one-cycle spike pulse
//           value_o  - current interval, TW bits, WINDOW+1 = invalid

module spike_timer
    import stdp_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEF,
    parameter int TW     = timer_width(WINDOW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spike_i,
    output logic [TW-1:0] value_o
);

    localparam logic [TW-1:0] INVALID = TW'(WINDOW + 1);
    localparam logic [TW-1:0] ONE     = TW'(1);

    // count_q already holds the value for the current cycle assuming no
    // spike; a spike overrides it to 0 combinationally so that the value
    // seen by the other side in a spike cycle is the true interval.
    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign value_o = spike_i ? '0 : count_q;

    always_comb begin
        count_d = count_q;
        if (value_o == INVALID) begin
            count_d = INVALID;
        end else begin
            count_d = value_o + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= INVALID;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stdp_synapse.sv
// rtl/stdp_synapse.sv - pair-based STDP synapse with saturating weight
//
// Purpose : holds one synaptic weight, potentiates it when a post spike
//           follows a pre spike within WINDOW cycles, depresses it when a
//           pre spike follows a post spike, and emits the weight as a
//           one-cycle current after each pre spike.
// Ports   : clk         - clock, rising edge
//           rst_n       - asynchronous active-low reset
//           pre_spike   - presynaptic spike pulse
//           post_spike  - postsynaptic spike pulse
//           learn_en    - 1 allows weight updates
//           weight      - registered weight, WIDTH bits
//           weight_upd  - pulse in the first cycle a changed weight is shown
//           current_out - registered current, pre-update weight after pre_spike
// Config  : STDP_EXP_EN defined -> step = base_step >> (dt >> 2);
//           undefined -> fixed step for any dt within WINDOW.

module stdp_synapse
    import stdp_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int WINDOW   = WINDOW_DEF,
    parameter int W_INIT   = W_INIT_DEF,
    parameter int LTP_STEP = LTP_STEP_DEF,
    parameter int LTD_STEP = LTD_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre_spike,
    input  logic             post_spike,
    input  logic             learn_en,
    output logic [WIDTH-1:0] weight,
    output logic             weight_upd,
    output logic [WIDTH-1:0] current_out
);

    localparam int TW = timer_width(WINDOW);
    localparam int W1 = WIDTH + 1;

    localparam logic [TW-1:0]    WIN_T  = TW'(WINDOW);
    localparam logic [W1-1:0]    STEP_P = W1'(LTP_STEP);
    localparam logic [W1-1:0]    STEP_D = W1'(LTD_STEP);
    localparam logic [WIDTH-1:0] W_RST  = WIDTH'(W_INIT);

    logic [TW-1:0] pre_t;
    logic [TW-1:0] post_t;

    logic [WIDTH-1:0] weight_q, weight_d;
    logic             upd_q, upd_d;
    logic [WIDTH-1:0] cur_q, cur_d;

    learn_ev_e        ev;
    logic [W1-1:0]    delta_p;
    logic [W1-1:0]    delta_d;
    logic [W1-1:0]    sum;
    logic [W1-1:0]    diff;

    spike_timer #(
        .WINDOW (WINDOW),
        .TW     (TW)
    ) u_pre_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .spike_i (pre_spike),
        .value_o (pre_t)
    );

    spike_timer #(
        .WINDOW (WINDOW),
        .TW     (TW)
    ) u_post_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .spike_i (post_spike),
        .value_o (post_t)
    );

    // Coincident spikes are ambiguous in ordering, so they never learn.
    always_comb begin
        ev = LEARN_NONE;
        if (post_spike && !pre_spike && (pre_t <= WIN_T)) begin
            ev = LEARN_LTP;
        end else if (pre_spike && !post_spike && (post_t <= WIN_T)) begin
            ev = LEARN_LTD;
        end
    end

`ifdef STDP_EXP_EN
    logic [TW-1:0] dt;

    always_comb begin
        dt      = (ev == LEARN_LTP) ? pre_t : post_t;
        delta_p = STEP_P >> (dt >> 2);
        delta_d = STEP_D >> (dt >> 2);
    end
`else
    always_comb begin
        delta_p = STEP_P;
        delta_d = STEP_D;
    end
`endif

    // One guard bit: carry out means overflow, borrow means underflow.
    assign sum  = {1'b0, weight_q} + delta_p;
    assign diff = {1'b0, weight_q} - delta_d;

    always_comb begin
        weight_d = weight_q;
        if (learn_en) begin
            case (ev)
                LEARN_LTP: weight_d = sum[WIDTH]  ? '1 : sum[WIDTH-1:0];
                LEARN_LTD: weight_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
                default:   weight_d = weight_q;
            endcase
        end
    end

    // Pulse only on a real change, which also covers zero deltas and
    // updates clipped at either rail.
    assign upd_d = (weight_d != weight_q);
    assign cur_d = pre_spike ? weight_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_q <= W_RST;
            upd_q    <= 1'b0;
            cur_q    <= '0;
        end else begin
            weight_q <= weight_d;
            upd_q    <= upd_d;
            cur_q    <= cur_d;
        end
    end

    assign weight      = weight_q;
    assign weight_upd  = upd_q;
    assign current_out = cur_q;

endmodule

// File: tb/tb_stdp_synapse.sv
// tb/tb_stdp_synapse.sv - self-checking bench for stdp_synapse against an interval model

module tb_stdp_synapse;

    localparam int WINDOW = 15;
    localparam int LTP    = 4;
    localparam int LTD    = 2;
    localparam int WMAX   = 255;
`ifdef STDP_EXP_EN
    localparam bit EXP_EN = 1'b1;
`else
    localparam bit EXP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pre_spike;
    logic       post_spike;
    logic       learn_en;
    logic [7:0] weight_a, current_a, weight_b, current_b;
    logic       upd_a, upd_b;

    always #5 clk = ~clk;

    stdp_synapse dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .pre_spike   (pre_spike),
        .post_spike  (post_spike),
        .learn_en    (learn_en),
        .weight      (weight_a),
        .weight_upd  (upd_a),
        .current_out (current_a)
    );

    stdp_synapse #(.W_INIT(254)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .pre_spike   (pre_spike),
        .post_spike  (post_spike),
        .learn_en    (learn_en),
        .weight      (weight_b),
        .weight_upd  (upd_b),
        .current_out (current_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: absolute cycle numbers of the last spikes, interval = difference.
    int init_w[2] = '{128, 254};
    int mw[2];
    int cyc;
    int last_pre, last_post;
    bit have_pre, have_post;
    int exp_cur[2];
    bit exp_upd[2];
    int upd_b_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int step_of(input int base, input int dt);
        int sh;
        sh = EXP_EN ? (dt / 4) : 0;
        return base >> sh;
    endfunction

    task automatic model_step(input bit p, input bit q, input bit l);
        int nw;
        for (int i = 0; i < 2; i++) begin
            exp_cur[i] = p ? mw[i] : 0;
            nw = mw[i];
            if (l && (p != q)) begin
                if (q && have_pre && (cyc - last_pre) <= WINDOW) begin
                    nw = mw[i] + step_of(LTP, cyc - last_pre);
                    if (nw > WMAX) nw = WMAX;
                end
                if (p && have_post && (cyc - last_post) <= WINDOW) begin
                    nw = mw[i] - step_of(LTD, cyc - last_post);
                    if (nw < 0) nw = 0;
                end
            end
            exp_upd[i] = (nw != mw[i]);
            mw[i] = nw;
        end
        if (p) begin last_pre = cyc;  have_pre = 1'b1; end
        if (q) begin last_post = cyc; have_post = 1'b1; end
        cyc++;
    endtask

    task automatic tick(input bit p, input bit q, input bit l);
        pre_spike  = p;
        post_spike = q;
        learn_en   = l;
        model_step(p, q, l);
        @(negedge clk);
        check("w_a",   32'(weight_a),  32'(mw[0]));
        check("upd_a", 32'(upd_a),     32'(exp_upd[0]));
        check("cur_a", 32'(current_a), 32'(exp_cur[0]));
        check("w_b",   32'(weight_b),  32'(mw[1]));
        check("upd_b", 32'(upd_b),     32'(exp_upd[1]));
        check("cur_b", 32'(current_b), 32'(exp_cur[1]));
        if (upd_b) upd_b_count++;
    endtask

    task automatic do_reset(input int hold);
        rst_n      = 1'b0;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        #1;
        check("rst_w_a",   32'(weight_a),  32'd128);
        check("rst_w_b",   32'(weight_b),  32'd254);
        check("rst_upd_a", 32'(upd_a),     32'd0);
        check("rst_cur_a", 32'(current_a), 32'd0);
        check("rst_upd_b", 32'(upd_b),     32'd0);
        check("rst_cur_b", 32'(current_b), 32'd0);
        for (int i = 0; i < 2; i++) mw[i] = init_w[i];
        have_pre  = 1'b0;
        have_post = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        learn_en   = 1'b1;
        cyc        = 0;
        upd_b_count = 0;
        @(negedge clk);
        do_reset(2);

        // pre at 0, post at 3
        tick(1, 0, 1); tick(0, 0, 1); tick(0, 0, 1); tick(0, 1, 1);
        check("ltp_w",   32'(weight_a), 32'd132);
        check("ltp_upd", 32'(upd_a),    32'd1);
        tick(0, 0, 1);
        check("ltp_upd_once", 32'(upd_a), 32'd0);

        // post at 0, pre at 5
        do_reset(1);
        tick(0, 1, 1);
        repeat (4) tick(0, 0, 1);
        tick(1, 0, 1);
        check("ltd_w",   32'(weight_a),  EXP_EN ? 32'd127 : 32'd126);
        check("ltd_cur", 32'(current_a), 32'd128);
        tick(0, 0, 1);
        check("cur_clear", 32'(current_a), 32'd0);

        // coincident spikes, then post 16 cycles later
        do_reset(1);
        tick(1, 1, 1);
        check("coin_upd", 32'(upd_a), 32'd0);
        repeat (15) tick(0, 0, 1);
        tick(0, 1, 1);
        check("late_w",   32'(weight_a), 32'd128);
        check("late_upd", 32'(upd_a),    32'd0);

        // saturation at the top rail on the W_INIT=254 instance
        do_reset(1);
        upd_b_count = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, 1);
            tick(0, 1, 1);
            check("sat_w", 32'(weight_b), 32'd255);
            repeat (16) tick(0, 0, 1);
        end
        check("sat_upd_count", 32'(upd_b_count), 32'd1);

`ifdef STDP_EXP_EN
        // decayed step at dt=9, then the same pair with learning frozen
        do_reset(1);
        tick(1, 0, 1);
        repeat (8) tick(0, 0, 1);
        tick(0, 1, 1);
        check("exp_w", 32'(weight_a), 32'd129);
        repeat (20) tick(0, 0, 1);
        tick(1, 0, 0);
        repeat (8) tick(0, 0, 0);
        tick(0, 1, 0);
        check("frozen_w",   32'(weight_a), 32'd129);
        check("frozen_upd", 32'(upd_a),    32'd0);
`endif

        // reset in the middle of a pairing interval
        do_reset(1);
        tick(1, 0, 1);
        tick(0, 0, 1);
        do_reset(2);
        tick(0, 0, 1);
        tick(0, 1, 1);
        check("mid_rst_w",   32'(weight_a), 32'd128);
        check("mid_rst_upd", 32'(upd_a),    32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                tick($urandom_range(0, 5) == 0,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 9) != 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
